// File: rtl/next_pc_btb_pkg.sv
// Shared types and constants for the next-PC branch target buffer.
// Entry layout and counter policy live here so the top and bench agree.
package next_pc_btb_pkg;

    localparam int BTB_PC_W  = 32;
    localparam int BTB_TAG_W = BTB_PC_W - 2;

    localparam logic [1:0] BTB_CTR_INIT = 2'b10;
    localparam logic [1:0] BTB_CTR_MAX  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_PC_W-1:0]  target;
        logic [1:0]           ctr;
    } btb_entry_t;

endpackage

// File: rtl/next_pc_btb_match.sv
// DEPTH-way tag compare with lowest-index priority encoding.
module next_pc_btb_match #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 30
) (
    input  logic [DEPTH-1:0]            valid_i,
    input  logic [DEPTH-1:0][TAG_W-1:0] tags_i,
    input  logic [TAG_W-1:0]            key_i,
    output logic                        match_o,
    output logic [ADDR_W-1:0]           index_o
);

    // Scan downward so the lowest matching index is the last one written.
    always_comb begin
        match_o = 1'b0;
        index_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_i[i] && (tags_i[i] == key_i)) begin
                match_o = 1'b1;
                index_o = ADDR_W'(i);
            end
        end
    end

endmodule

// File: rtl/next_pc_btb.sv
// Fully associative BTB: registered next-PC prediction per fetch PC,
// 2-bit counter training and allocation from resolved branches.
module next_pc_btb
    import next_pc_btb_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int PC_W   = BTB_PC_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lookup_valid_i,
    input  logic [PC_W-1:0]   lookup_pc_i,
    input  logic              branch_request_i,
    input  logic              branch_is_taken_i,
    input  logic [PC_W-1:0]   branch_source_i,
    input  logic [PC_W-1:0]   branch_pc_i,
    input  logic [ADDR_W-1:0] alloc_entry_i,
    output logic              pred_valid_o,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [PC_W-1:0]   pred_pc_o,
    output logic              hit_o,
    output logic [ADDR_W-1:0] hit_entry_o,
    output logic              alloc_o
);

    localparam int TAG_W = PC_W - 2;

    btb_entry_t btb_q [DEPTH];
    btb_entry_t btb_d [DEPTH];

    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0][TAG_W-1:0] tags;

    logic [TAG_W-1:0]  lk_tag;
    logic [TAG_W-1:0]  up_tag;
    logic              lk_match;
    logic [ADDR_W-1:0] lk_idx;
    logic              up_match;
    logic [ADDR_W-1:0] up_idx;

    logic              pred_valid_q, pred_valid_d;
    logic              pred_hit_q, pred_hit_d;
    logic              pred_taken_q, pred_taken_d;
    logic [PC_W-1:0]   pred_pc_q, pred_pc_d;
    logic [ADDR_W-1:0] hit_entry_q, hit_entry_d;

    assign lk_tag = lookup_pc_i[PC_W-1:2];
    assign up_tag = branch_source_i[PC_W-1:2];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            vld[i]  = btb_q[i].valid;
            tags[i] = btb_q[i].tag;
        end
    end

    next_pc_btb_match #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .TAG_W (TAG_W)
    ) u_lookup_match (
        .valid_i(vld),
        .tags_i (tags),
        .key_i  (lk_tag),
        .match_o(lk_match),
        .index_o(lk_idx)
    );

    next_pc_btb_match #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .TAG_W (TAG_W)
    ) u_update_match (
        .valid_i(vld),
        .tags_i (tags),
        .key_i  (up_tag),
        .match_o(up_match),
        .index_o(up_idx)
    );

    assign alloc_o = branch_request_i && branch_is_taken_i
                   && !up_match && !rst_i;

    always_comb begin
        btb_d = btb_q;
        if (branch_request_i) begin
            if (up_match) begin
                if (branch_is_taken_i) begin
                    btb_d[up_idx].target = branch_pc_i;
                    if (btb_q[up_idx].ctr != BTB_CTR_MAX) begin
                        btb_d[up_idx].ctr = btb_q[up_idx].ctr + 2'd1;
                    end
                end else if (btb_q[up_idx].ctr != 2'd0) begin
                    btb_d[up_idx].ctr = btb_q[up_idx].ctr - 2'd1;
                end
            end else if (branch_is_taken_i) begin
                btb_d[alloc_entry_i].valid  = 1'b1;
                btb_d[alloc_entry_i].tag    = up_tag;
                btb_d[alloc_entry_i].target = branch_pc_i;
                btb_d[alloc_entry_i].ctr    = BTB_CTR_INIT;
            end
        end
    end

    // Prediction reads the pre-update array (read-before-write).
    always_comb begin
        pred_valid_d = lookup_valid_i;
        pred_hit_d   = lookup_valid_i && lk_match;
        pred_taken_d = pred_hit_d && btb_q[lk_idx].ctr[1];
        hit_entry_d  = pred_hit_d ? lk_idx : '0;
        pred_pc_d    = {lk_tag + TAG_W'(1), 2'b00};
        if (pred_taken_d) begin
            pred_pc_d = btb_q[lk_idx].target;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                btb_q[i] <= '0;
            end
            pred_valid_q <= 1'b0;
            pred_hit_q   <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_pc_q    <= '0;
            hit_entry_q  <= '0;
        end else begin
            btb_q        <= btb_d;
            pred_valid_q <= pred_valid_d;
            pred_hit_q   <= pred_hit_d;
            pred_taken_q <= pred_taken_d;
            pred_pc_q    <= pred_pc_d;
            hit_entry_q  <= hit_entry_d;
        end
    end

    assign pred_valid_o = pred_valid_q;
    assign pred_hit_o   = pred_hit_q;
    assign pred_taken_o = pred_taken_q;
    assign pred_pc_o    = pred_pc_q;
    assign hit_o        = pred_hit_q;
    assign hit_entry_o  = hit_entry_q;

endmodule

// File: tb/tb_next_pc_btb.sv
// Bench for next_pc_btb: directed scenarios then random traffic,
// all checked against an array-based behavioural model.
module tb_next_pc_btb;

    logic        clk_i;
    logic        rst_i;
    logic        lookup_valid_i;
    logic [31:0] lookup_pc_i;
    logic        branch_request_i;
    logic        branch_is_taken_i;
    logic [31:0] branch_source_i;
    logic [31:0] branch_pc_i;
    logic [4:0]  alloc_entry_i;
    logic        pred_valid_o;
    logic        pred_hit_o;
    logic        pred_taken_o;
    logic [31:0] pred_pc_o;
    logic        hit_o;
    logic [4:0]  hit_entry_o;
    logic        alloc_o;

    int n_tests;
    int n_fail;

    bit          m_valid  [32];
    logic [31:0] m_src    [32];
    logic [31:0] m_target [32];
    int          m_ctr    [32];

    next_pc_btb dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .lookup_valid_i   (lookup_valid_i),
        .lookup_pc_i      (lookup_pc_i),
        .branch_request_i (branch_request_i),
        .branch_is_taken_i(branch_is_taken_i),
        .branch_source_i  (branch_source_i),
        .branch_pc_i      (branch_pc_i),
        .alloc_entry_i    (alloc_entry_i),
        .pred_valid_o     (pred_valid_o),
        .pred_hit_o       (pred_hit_o),
        .pred_taken_o     (pred_taken_o),
        .pred_pc_o        (pred_pc_o),
        .hit_o            (hit_o),
        .hit_entry_o      (hit_entry_o),
        .alloc_o          (alloc_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Word-aligned PC equality; lowest entry wins.
    function automatic int m_find(input logic [31:0] pc);
        for (int i = 0; i < 32; i++) begin
            if (m_valid[i] && (m_src[i] >> 2) == (pc >> 2)) return i;
        end
        return -1;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_valid[i]  = 1'b0;
            m_src[i]    = '0;
            m_target[i] = '0;
            m_ctr[i]    = 0;
        end
    endtask

    task automatic step(input bit rst, input bit lv, input logic [31:0] lpc,
                        input bit br, input bit tk, input logic [31:0] src,
                        input logic [31:0] tgt, input logic [4:0] ae);
        int          idx;
        int          uidx;
        bit          e_valid, e_hit, e_taken, e_alloc;
        logic [31:0] e_pc;
        logic [31:0] e_ent;
        rst_i             = rst;
        lookup_valid_i    = lv;
        lookup_pc_i       = lpc;
        branch_request_i  = br;
        branch_is_taken_i = tk;
        branch_source_i   = src;
        branch_pc_i       = tgt;
        alloc_entry_i     = ae;
        #1;
        uidx    = m_find(src);
        e_alloc = !rst && br && tk && (uidx < 0);
        check("alloc_o", 32'(alloc_o), 32'(e_alloc));

        idx     = m_find(lpc);
        e_valid = lv;
        e_hit   = lv && (idx >= 0);
        e_taken = e_hit && (m_ctr[idx] >= 2);
        e_pc    = e_taken ? m_target[idx] : ((lpc & 32'hFFFF_FFFC) + 32'd4);
        e_ent   = e_hit ? 32'(idx) : 32'd0;
        if (rst) begin
            e_valid = 0; e_hit = 0; e_taken = 0; e_pc = 0; e_ent = 0;
        end

        @(posedge clk_i);
        if (rst) begin
            m_clear();
        end else if (br) begin
            if (uidx >= 0) begin
                if (tk) begin
                    m_target[uidx] = tgt;
                    m_ctr[uidx] = (m_ctr[uidx] < 3) ? m_ctr[uidx] + 1 : 3;
                end else begin
                    m_ctr[uidx] = (m_ctr[uidx] > 0) ? m_ctr[uidx] - 1 : 0;
                end
            end else if (tk) begin
                m_valid[ae]  = 1'b1;
                m_src[ae]    = src;
                m_target[ae] = tgt;
                m_ctr[ae]    = 2;
            end
        end
        #1;
        check("pred_valid", 32'(pred_valid_o), 32'(e_valid));
        check("pred_hit", 32'(pred_hit_o), 32'(e_hit));
        check("pred_taken", 32'(pred_taken_o), 32'(e_taken));
        check("pred_pc", pred_pc_o, e_pc);
        check("hit_o", 32'(hit_o), 32'(e_hit));
        check("hit_entry", 32'(hit_entry_o), e_ent);
    endtask

    task automatic look(input logic [31:0] pc);
        step(0, 1, pc, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input logic [31:0] src, input bit tk,
                       input logic [31:0] tgt, input logic [4:0] ae);
        step(0, 0, 0, 1, tk, src, tgt, ae);
    endtask

    initial begin
        logic [31:0] pc, src;
        n_tests = 0;
        n_fail  = 0;
        m_clear();

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 32'h100, 1, 1, 32'h100, 32'h200, 5'd3);
        check("reset_pc", pred_pc_o, 32'h0);

        look(32'h100);
        check("empty_pc", pred_pc_o, 32'h104);

        upd(32'h100, 1, 32'h200, 5'd5);
        look(32'h100);
        check("alloc_entry", 32'(hit_entry_o), 32'd5);
        check("alloc_target", pred_pc_o, 32'h200);

        repeat (4) upd(32'h100, 1, 32'h200, 5'd9);
        repeat (2) upd(32'h100, 0, 32'h0, 5'd9);
        look(32'h100);
        check("ctr1_pc", pred_pc_o, 32'h104);
        repeat (3) upd(32'h100, 0, 32'h0, 5'd9);
        upd(32'h100, 1, 32'h200, 5'd9);
        look(32'h100);
        check("ctr_floor_taken", 32'(pred_taken_o), 32'd0);
        upd(32'h100, 1, 32'h200, 5'd9);

        step(0, 1, 32'h100, 1, 0, 32'h100, 32'h0, 5'd0);
        check("rbw_taken", 32'(pred_taken_o), 32'd1);
        look(32'h100);
        check("after_upd_taken", 32'(pred_taken_o), 32'd0);

        step(0, 1, 32'h700, 1, 1, 32'h700, 32'h780, 5'd7);
        look(32'h700);

        upd(32'h300, 0, 32'h0, 5'd4);
        look(32'h300);
        look(32'hFFFF_FFFC);
        check("wrap_pc", pred_pc_o, 32'h0);

        upd(32'h400, 1, 32'h440, 5'd1);
        upd(32'h500, 1, 32'h540, 5'd2);
        upd(32'h600, 1, 32'h640, 5'd3);
        step(1, 1, 32'h400, 1, 1, 32'h800, 32'h900, 5'd6);
        look(32'h400);
        look(32'h500);
        look(32'h600);
        look(32'h800);

        for (int n = 0; n < 3000; n++) begin
            pc  = 32'h1000 + ($urandom_range(0, 23) << 2) + $urandom_range(0, 3);
            src = 32'h1000 + ($urandom_range(0, 23) << 2) + $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) pc = 32'hFFFF_FFFC;
            step(($urandom_range(0, 199) == 0), 1'($urandom), pc,
                 1'($urandom), 1'($urandom), src, $urandom,
                 5'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/next_pc_btb.md
# next_pc_btb

Fully associative branch target buffer for the next-PC stage. It looks up each fetch PC and returns a registered prediction: hit, predicted taken, and next PC. Resolved branches from execute update per-entry 2-bit counters and targets. On a taken miss it allocates the entry named by the LFSR replacement block, which sits directly downstream and consumes this block's `alloc_o`, `hit_o` and `hit_entry_o`.

## Interface
- `DEPTH`, 32, number of entries.
- `ADDR_W`, 5, entry index width; `DEPTH == 2**ADDR_W`.
- `PC_W`, 32, PC width.
- `clk_i` in 1: sole clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `lookup_valid_i` in 1: fetch PC presented this cycle.
- `lookup_pc_i` in PC_W: fetch PC.
- `branch_request_i` in 1: resolved branch update this cycle.
- `branch_is_taken_i` in 1: resolved direction.
- `branch_source_i` in PC_W: PC of the branch instruction.
- `branch_pc_i` in PC_W: resolved target.
- `alloc_entry_i` in ADDR_W: victim index from the LFSR replacement block.
- `pred_valid_o` out 1: prediction valid (registered `lookup_valid_i`).
- `pred_hit_o` out 1: lookup matched a valid entry.
- `pred_taken_o` out 1: hit and counter[1] set.
- `pred_pc_o` out PC_W: stored target if `pred_taken_o`, else `{lookup_pc[PC_W-1:2]+1, 2'b00}`.
- `hit_o` out 1: registered lookup hit, to the replacement block.
- `hit_entry_o` out ADDR_W: matching index (0 on miss).
- `alloc_o` out 1: combinational allocate strobe, to the replacement block.

## Operation
- Per entry: `valid`, `tag = pc[PC_W-1:2]`, `target[PC_W-1:0]`, `ctr[1:0]`.
- Lookup compares `lookup_pc_i[PC_W-1:2]` against all valid tags. Allocation only occurs on a miss, so at most one entry matches. If duplicates ever exist, the lowest index wins.
- Update compares `branch_source_i[PC_W-1:2]` the same way.
  - Update hit, taken: `ctr` saturating increment (max 3); `target <= branch_pc_i`.
  - Update hit, not taken: `ctr` saturating decrement (min 0); target unchanged.
  - Update miss, taken: `alloc_o=1`. Entry `alloc_entry_i` gets `valid=1`, the new tag, `target=branch_pc_i`, `ctr=2'b10`. Any prior contents of that entry are overwritten.
  - Update miss, not taken: no state change, `alloc_o=0`.
- `alloc_o` is high only while `branch_request_i` is high. It is never asserted during reset.
- Address width rule: `pred_pc_o` fall-through is `+4` modulo 2^PC_W. At `lookup_pc_i = 32'hFFFF_FFFC` it wraps to `32'h0000_0000`.

## Timing
- Lookup latency is 1 cycle. Inputs are sampled at edge N; `pred_*`, `hit_o` and `hit_entry_o` are valid after edge N and held until the next edge.
- When `lookup_valid_i=0`, the next cycle has `pred_valid_o=0` and `pred_hit_o=pred_taken_o=hit_o=0`. `pred_pc_o` still shows the fall-through PC.
- Lookup and update in the same cycle: the lookup sees pre-update array state (read-before-write). This includes an update hitting the same entry and an allocation whose tag equals `lookup_pc_i`.
- An update becomes visible to lookups issued in the following cycle.
- Reset:
  - Every `valid` clears. `ctr`, `tag` and `target` clear to 0.
  - All registered outputs are 0, including `pred_pc_o`.
  - Reset asserted mid-stream discards the in-flight prediction and any same-cycle update.
  - The first lookup after reset deasserts sees an empty BTB.

## Structure
- Shared package: `BTB_CTR_INIT=2'b10`, `BTB_CTR_MAX=2'b11`, and the entry typedef `{valid, tag, target, ctr}`.
- One sub-module, `next_pc_btb_match`: a combinational DEPTH-way tag compare with a lowest-index priority encoder, outputting `match` and `index`.
- Instantiate it twice: once for the lookup port and once for the update port.
- The array, counter update logic and output registers live in the top.

## Test plan
- **Post-reset empty lookup:** lookup `0x100` one cycle after reset → `pred_valid_o=1`, `pred_hit_o=0`, `pred_taken_o=0`, `pred_pc_o=0x104`, `alloc_o=0`.
- **Taken miss allocates:** update `source=0x100`, `target=0x200`, taken, `alloc_entry_i=5` → `alloc_o=1` that cycle. Next-cycle lookup `0x100` → hit, `hit_entry_o=5`, taken, `pred_pc_o=0x200`.
- **Counter saturation:**
  - Four taken updates to `0x100` → `ctr=3`.
  - Then two not-taken updates → `ctr=1`; lookup → hit, `pred_taken_o=0`, `pred_pc_o=0x104`.
  - Then further not-taken updates → `ctr` stays 0.
- **Same-cycle lookup and update:** entry `0x100` with `ctr=2`; lookup `0x100` plus not-taken update of `0x100` in one cycle → prediction taken (old state). Lookup the next cycle → not taken.
- **Not-taken miss, then wrap:** not-taken update of `0x300` → `alloc_o=0` and no entry is created. Lookup `0xFFFF_FFFC` → `pred_pc_o=0x0`.
- **Reset mid-operation:** fill 3 entries, assert `rst_i` for 1 cycle during a lookup → all outputs 0. Subsequent lookups of the filled PCs → miss.
